dds_nco_multi: RTL

DDS_NCO_MULTI -- requirements
Module: dds_nco_multi

---
 rtl/dds_nco_multi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dds_nco_multi.sv
// dds_nco_multi: NCH independent phase-accumulator sine NCOs sharing one full-wave table built at elaboration.
// Latency: accumulator value to sine_out is 3 cycles (index, table, scale); out_valid is enable delayed by 3.
// Backpressure: cfg_ready drops for the one cycle after an accepted write (nothing is queued); the sample path never stalls.
//
// Ports:
//   clk, rst (async, active-low)          clock and reset
//   enable, sync                          advance / synchronously clear all accumulators
//   cfg_valid/cfg_ready, cfg_ch, cfg_ftw,
//   cfg_phase, cfg_amp, cfg_err           per-channel configuration write and bad-channel pulse
//   out_valid, sine_out, wrap             packed samples (channel k at [k*OUT_W +: OUT_W]), overflow pulses
module dds_nco_multi #(
    parameter int NCH    = 2,
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 14,
    parameter int AMP_W  = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_W-1:0]     cfg_ftw,
    input  logic [LUT_AW-1:0]    cfg_phase,
    input  logic [AMP_W-1:0]     cfg_amp,
    output logic                 cfg_err,
    output logic                 out_valid,
    output logic [NCH*OUT_W-1:0] sine_out,
    output logic [NCH-1:0]       wrap
);

    localparam int  LUT_N  = 1 << LUT_AW;
    localparam int  PROD_W = OUT_W + AMP_W + 1;
    localparam real PI     = 3.14159265358979323846;

    // round-half-away-from-zero of full-scale sine, evaluated only at elaboration
    function automatic logic signed [OUT_W-1:0] sin_entry(input int idx);
        real x;
        real r;
        x = real'((1 << (OUT_W - 1)) - 1) * $sin(2.0 * PI * real'(idx) / real'(LUT_N));
        r = (x >= 0.0) ? $floor(x + 0.5) : -$floor(0.5 - x);
        return OUT_W'($rtoi(r));
    endfunction

    logic signed [OUT_W-1:0] lut_rom [LUT_N];

    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        localparam logic signed [OUT_W-1:0] ENTRY = sin_entry(gi);
        assign lut_rom[gi] = ENTRY;
    end

    // configuration handshake and shadow set
    logic              cfg_ready_q;
    logic              pend_q;
    logic [CH_W-1:0]   sh_ch_q;
    logic [ACC_W-1:0]  sh_ftw_q;
    logic [LUT_AW-1:0] sh_phase_q;
    logic [AMP_W-1:0]  sh_amp_q;
    logic              err_q;
    logic [2:0]        en_q;

    // per-channel active set, accumulator and pipeline
    logic [ACC_W-1:0]        ftw_q   [NCH];
    logic [LUT_AW-1:0]       phase_q [NCH];
    logic [AMP_W-1:0]        amp_q   [NCH];
    logic [ACC_W-1:0]        acc_q   [NCH];
    logic [NCH-1:0]          wrap_q;
    logic [LUT_AW-1:0]       idx_q   [NCH];
    logic signed [OUT_W-1:0] lut_q   [NCH];
    logic [AMP_W-1:0]        amp2_q  [NCH];
    logic signed [OUT_W-1:0] out_q   [NCH];

    logic                    accept;
    logic                    ch_ok;
    logic [NCH-1:0]          commit;
    logic [ACC_W:0]          sum_d   [NCH];
    logic [LUT_AW-1:0]       phase_d [NCH];
    logic [AMP_W-1:0]        amp_d   [NCH];
    logic [LUT_AW-1:0]       idx_d   [NCH];
    logic signed [PROD_W-1:0] prod_d [NCH];
    logic signed [OUT_W-1:0] scaled_d [NCH];

    assign accept = cfg_valid && cfg_ready_q;
    assign ch_ok  = ({1'b0, sh_ch_q} < (CH_W + 1)'(NCH));

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            commit[k]  = pend_q && ch_ok && (sh_ch_q == CH_W'(k));
            // carry out of the add becomes the wrap pulse
            sum_d[k]   = {1'b0, acc_q[k]} + {1'b0, ftw_q[k]};
            // a committing phase/amp is used by stages 1/2 on the commit edge itself
            phase_d[k] = commit[k] ? sh_phase_q : phase_q[k];
            amp_d[k]   = commit[k] ? sh_amp_q : amp_q[k];
            idx_d[k]   = acc_q[k][ACC_W-1 -: LUT_AW] + phase_d[k];
            // amp < 2^AMP_W so |lut*amp| >> AMP_W stays inside OUT_W; >>> floors
            prod_d[k]  = PROD_W'(lut_q[k]) * PROD_W'($signed({1'b0, amp2_q[k]}));
            scaled_d[k] = OUT_W'(prod_d[k] >>> AMP_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ready_q <= 1'b0;
            pend_q      <= 1'b0;
            sh_ch_q     <= '0;
            sh_ftw_q    <= '0;
            sh_phase_q  <= '0;
            sh_amp_q    <= '0;
            err_q       <= 1'b0;
            en_q        <= '0;
            wrap_q      <= '0;
            for (int k = 0; k < NCH; k++) begin
                ftw_q[k]   <= '0;
                phase_q[k] <= '0;
                amp_q[k]   <= '0;
                acc_q[k]   <= '0;
                idx_q[k]   <= '0;
                lut_q[k]   <= '0;
                amp2_q[k]  <= '0;
                out_q[k]   <= '0;
            end
        end else begin
            cfg_ready_q <= !accept;
            pend_q      <= accept;
            if (accept) begin
                sh_ch_q    <= cfg_ch;
                sh_ftw_q   <= cfg_ftw;
                sh_phase_q <= cfg_phase;
                sh_amp_q   <= cfg_amp;
            end
            err_q <= pend_q && !ch_ok;
            en_q  <= {en_q[1:0], enable};
            for (int k = 0; k < NCH; k++) begin
                // commit never touches the accumulator; the new ftw is used from the next update
                if (commit[k]) begin
                    ftw_q[k]   <= sh_ftw_q;
                    phase_q[k] <= sh_phase_q;
                    amp_q[k]   <= sh_amp_q;
                end
                if (sync) begin
                    acc_q[k]  <= '0;
                    wrap_q[k] <= 1'b0;
                end else if (enable) begin
                    acc_q[k]  <= sum_d[k][ACC_W-1:0];
                    wrap_q[k] <= sum_d[k][ACC_W];
                end else begin
                    wrap_q[k] <= 1'b0;
                end
                idx_q[k]  <= idx_d[k];
                lut_q[k]  <= lut_rom[idx_q[k]];
                amp2_q[k] <= amp_d[k];
                out_q[k]  <= scaled_d[k];
            end
        end
    end

    always_comb begin
        sine_out = '0;
        for (int k = 0; k < NCH; k++) begin
            sine_out[k*OUT_W +: OUT_W] = out_q[k];
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = err_q;
    assign out_valid = en_q[2];
    assign wrap      = wrap_q;

endmodule
